// File: rtl/regfile_context_engine.sv
// regfile_context_engine: walks registers FIRST_REG..LAST_REG, storing them to memory on save
// and reloading them from memory on restore, one memory request outstanding at a time.
module regfile_context_engine #(
   parameter int FIRST_REG   = 1,
   parameter int LAST_REG    = 31,
   parameter int ADDR_STRIDE = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_save_req,
   input  logic        i_restore_req,
   input  logic [63:0] i_base_addr,
   output logic        o_busy,
   output logic        o_done,
   output logic [4:0]  o_rf_read_reg,
   input  logic [63:0] i_rf_read_data,
   output logic [4:0]  o_rf_write_reg,
   output logic        o_rf_write_en,
   output logic [63:0] o_rf_write_data,
   output logic        o_mem_req_valid,
   input  logic        i_mem_req_ready,
   output logic        o_mem_req_write,
   output logic [63:0] o_mem_req_addr,
   output logic [63:0] o_mem_req_wdata,
   input  logic        i_mem_rsp_valid,
   input  logic [63:0] i_mem_rsp_data
);
   typedef enum logic [2:0] {IDLE, SAVE_RD, SAVE_REQ, RST_REQ, RST_WAIT} state_t;

   state_t      r_state;
   logic [4:0]  r_idx;
   logic [4:0]  r_wr_reg;
   logic [63:0] r_addr;
   logic [63:0] r_wdata;
   logic [63:0] r_wr_data;
   logic        r_done;
   logic        r_wr_en;
   logic        w_last;

   assign w_last          = r_idx == 5'(LAST_REG);
   assign o_busy          = r_state != IDLE;
   assign o_done          = r_done;
   assign o_mem_req_valid = r_state == SAVE_REQ || r_state == RST_REQ;
   assign o_mem_req_write = r_state == SAVE_REQ;
   assign o_mem_req_addr  = o_mem_req_valid ? r_addr : '0;
   assign o_mem_req_wdata = o_mem_req_write ? r_wdata : '0;
   assign o_rf_read_reg   = r_state == SAVE_RD ? r_idx : '0;
   assign o_rf_write_en   = r_wr_en;
   assign o_rf_write_reg  = r_wr_reg;
   assign o_rf_write_data = r_wr_data;

   // r_addr tracks base + (idx-FIRST_REG)*ADDR_STRIDE incrementally, wrapping mod 2^64
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_done    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_reg  <= '0;
         r_wr_data <= '0;
      end else begin
         r_done  <= 1'b0;
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: if (i_save_req || i_restore_req) begin
               r_state <= i_save_req ? SAVE_RD : RST_REQ;
               r_addr  <= i_base_addr;
               r_idx   <= 5'(FIRST_REG);
            end
            SAVE_RD: begin
               r_wdata <= i_rf_read_data;
               r_state <= SAVE_REQ;
            end
            SAVE_REQ: if (i_mem_req_ready) begin
               r_state <= w_last ? IDLE : SAVE_RD;
               r_done  <= w_last;
               r_idx   <= w_last ? r_idx : r_idx + 5'd1;
               r_addr  <= w_last ? r_addr : r_addr + 64'(ADDR_STRIDE);
            end
            RST_REQ: if (i_mem_req_ready) r_state <= RST_WAIT;
            RST_WAIT: if (i_mem_rsp_valid) begin
               r_wr_en   <= 1'b1;
               r_wr_reg  <= r_idx;
               r_wr_data <= i_mem_rsp_data;
               r_state   <= w_last ? IDLE : RST_REQ;
               r_done    <= w_last;
               r_idx     <= w_last ? r_idx : r_idx + 5'd1;
               r_addr    <= w_last ? r_addr : r_addr + 64'(ADDR_STRIDE);
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_context_engine.sv
// tb_regfile_context_engine: randomized save/restore traffic against a queue-based scoreboard
// with a behavioural register file and a fixed-latency memory responder.
module tb_regfile_context_engine;
   localparam int FR = 1;
   localparam int LR = 31;
   localparam int ST = 8;

   typedef struct packed {logic w; logic [63:0] a; logic [63:0] d;} req_t;
   typedef struct packed {logic [4:0] r; logic [63:0] d;} wr_t;

   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_save_req = 1'b0, i_restore_req = 1'b0;
   logic [63:0] i_base_addr = '0, i_rf_read_data, i_mem_rsp_data = '0;
   logic        i_mem_req_ready = 1'b1, i_mem_rsp_valid = 1'b0;
   logic        o_busy, o_done, o_rf_write_en, o_mem_req_valid, o_mem_req_write;
   logic [4:0]  o_rf_read_reg, o_rf_write_reg;
   logic [63:0] o_rf_write_data, o_mem_req_addr, o_mem_req_wdata;

   logic [63:0] rf [32];
   req_t        exp_req[$];
   wr_t         exp_wr[$];
   req_t        er;
   wr_t         ew;
   int          n_chk = 0, n_fail = 0, busy_cyc = 0, done_cnt = 0, b0 = 0, d0 = 0;
   int          mode = 0, lat = 3, hold = 0, cnt = 0;
   bit          resp_en = 1, inject = 0, op_rst = 0, hs_load = 0;
   logic [63:0] ld_addr = '0, raddr = '0;

   regfile_context_engine #(.FIRST_REG(FR), .LAST_REG(LR), .ADDR_STRIDE(ST)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_save_req(i_save_req), .i_restore_req(i_restore_req),
      .i_base_addr(i_base_addr), .o_busy(o_busy), .o_done(o_done), .o_rf_read_reg(o_rf_read_reg),
      .i_rf_read_data(i_rf_read_data), .o_rf_write_reg(o_rf_write_reg), .o_rf_write_en(o_rf_write_en),
      .o_rf_write_data(o_rf_write_data), .o_mem_req_valid(o_mem_req_valid),
      .i_mem_req_ready(i_mem_req_ready), .o_mem_req_write(o_mem_req_write),
      .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wdata(o_mem_req_wdata),
      .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_data(i_mem_rsp_data)
   );

   always #5 i_clk = ~i_clk;
   assign i_rf_read_data = rf[o_rf_read_reg];

   task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, a, e);
      end
   endtask

   function automatic logic [206:0] outs();
      return {o_busy, o_done, o_rf_read_reg, o_rf_write_reg, o_rf_write_en, o_rf_write_data,
              o_mem_req_valid, o_mem_req_write, o_mem_req_addr, o_mem_req_wdata};
   endfunction

   // monitor: every request/write the DUT presents must match the head of its queue
   initial forever begin
      @(negedge i_clk);
      hs_load = 0;
      if (i_rst_n) begin
         busy_cyc += int'(o_busy);
         if (o_mem_req_valid) begin
            if (exp_req.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_req actual=%0h required=none", o_mem_req_addr);
            end else begin
               er = exp_req[0];
               chk("mem_req", {o_mem_req_write, o_mem_req_addr, o_mem_req_wdata}, {er.w, er.a, er.d});
               if (i_mem_req_ready) void'(exp_req.pop_front());
               hs_load = i_mem_req_ready && !o_mem_req_write;
               ld_addr = o_mem_req_addr;
            end
         end else chk("idle_bus_zero", {o_mem_req_addr, o_mem_req_wdata}, '0);
         if (o_rf_write_en) begin
            if (exp_wr.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_write actual=%0h required=none", o_rf_write_reg);
            end else begin
               ew = exp_wr.pop_front();
               chk("rf_write", {o_rf_write_reg, o_rf_write_data}, {ew.r, ew.d});
            end
         end
         if (o_done) begin
            done_cnt++;
            chk("done_busy_low", o_busy, 0);
            chk("done_with_last_write", o_rf_write_en, op_rst);
         end
      end
   end

   // memory side: ready pattern and load responses L cycles after the handshake
   initial forever begin
      @(posedge i_clk); #1;
      i_mem_rsp_valid = 1'b0;
      if (!resp_en) cnt = 0;
      else if (hs_load) begin cnt = lat; raddr = ld_addr; end
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) begin i_mem_rsp_valid = 1'b1; i_mem_rsp_data = 64'hA0 + raddr; end
      end
      if (inject) begin i_mem_rsp_valid = 1'b1; i_mem_rsp_data = {$urandom, $urandom}; end
      if (mode == 0) begin i_mem_req_ready = 1'b1; hold = 0; end
      else if (mode == 1) begin i_mem_req_ready = 1'($urandom_range(0, 1)); hold = 0; end
      else if (o_mem_req_valid && o_mem_req_addr == 64'h8010 && hold < 5) begin
         i_mem_req_ready = 1'b0; hold++;
      end else i_mem_req_ready = 1'b1;
   end

   task automatic start(input bit sv, input bit rs, input logic [63:0] base);
      logic [63:0] a;
      @(posedge i_clk); #1;
      for (int i = FR; i <= LR; i++) begin
         a = base + 64'((i - FR) * ST);
         if (sv) exp_req.push_back('{1'b1, a, rf[i]});
         else begin
            exp_req.push_back('{1'b0, a, 64'd0});
            exp_wr.push_back('{5'(i), 64'hA0 + a});
         end
      end
      op_rst = !sv;
      i_save_req = sv; i_restore_req = rs; i_base_addr = base;
      b0 = busy_cyc; d0 = done_cnt;
      @(posedge i_clk); #1;
      i_save_req = 1'b0; i_restore_req = 1'b0; i_base_addr = {$urandom, $urandom};
   endtask

   task automatic finish_op(input string nm, input int exp_busy);
      int k = 0;
      while (done_cnt == d0 && k < 5000) begin @(posedge i_clk); k++; end
      repeat (3) @(negedge i_clk);
      chk({nm, "_done_count"}, done_cnt - d0, 1);
      if (exp_busy >= 0) chk({nm, "_busy_cycles"}, busy_cyc - b0, exp_busy);
      chk({nm, "_queues_empty"}, exp_req.size() + exp_wr.size(), 0);
   endtask

   initial begin
      int k;
      logic [63:0] base;
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
      repeat (8) begin
         @(posedge i_clk); #1;
         i_save_req = 1'($urandom); i_restore_req = 1'($urandom); i_base_addr = {$urandom, $urandom};
         @(negedge i_clk);
         chk("reset_outputs", outs(), '0);
      end
      i_save_req = 1'b0; i_restore_req = 1'b0;
      @(posedge i_clk); #1 i_rst_n = 1'b1;
      repeat (6) begin @(negedge i_clk); chk("idle_no_busy", o_busy, 0); end

      start(1, 0, 64'h8000);
      finish_op("full_save", 62);

      mode = 2;
      start(1, 0, 64'h8000);
      finish_op("save_backpressure", 67);
      mode = 0;

      lat = 3;
      start(0, 1, 64'h9000);
      finish_op("full_restore", 124);

      start(1, 1, 64'h8400);
      finish_op("priority_save", 62);

      start(1, 0, 64'h8800);
      repeat (10) @(posedge i_clk);
      #1 i_restore_req = 1'b1;
      @(posedge i_clk); #1 i_restore_req = 1'b0;
      finish_op("restore_ignored", 62);
      repeat (20) @(negedge i_clk);
      chk("stays_idle", o_busy, 0);

      for (int t = 0; t < 4; t++) begin
         for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
         base = t == 1 ? 64'hFFFF_FFFF_FFFF_FFC0 : {$urandom, $urandom};
         mode = 1; lat = $urandom_range(1, 4);
         start(t % 2 == 0, t % 2 == 1, base);
         finish_op(t % 2 == 0 ? "rand_save" : "rand_restore", -1);
      end
      mode = 0; lat = 3;

      base = 64'hA000;
      start(0, 1, base);
      k = 0;
      do begin
         @(negedge i_clk); k++;
      end while (!(o_mem_req_valid && !o_mem_req_write && i_mem_req_ready && o_mem_req_addr == base + 64'd48) && k < 1000);
      chk("reached_x7_load", k < 1000, 1);
      @(posedge i_clk); #2;
      resp_en = 0;
      i_rst_n = 1'b0;
      #1 chk("async_reset_outputs", outs(), '0);
      exp_req.delete(); exp_wr.delete();
      repeat (3) @(posedge i_clk);
      #1 i_rst_n = 1'b1; resp_en = 1;
      @(posedge i_clk); #2 inject = 1;
      @(posedge i_clk); #2 inject = 0;
      repeat (5) begin
         @(negedge i_clk);
         chk("late_rsp_ignored", {o_rf_write_en, o_busy}, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end
endmodule
